// File: rtl/montgomery_pkg.sv
// Shared types and helpers for the Montgomery streaming controller and its bench.
// The qH helper works on plain integers so the same rule serves any LOGQH up to 63.
package montgomery_pkg;

    typedef enum logic [1:0] {
        CFG_WAIT = 2'd0,
        RUN      = 2'd1,
        DRAIN    = 2'd2,
        APPLY    = 2'd3
    } ctrl_state_t;

    function automatic int logc_of(input int logq);
        return 2 * logq;
    endfunction

    // qH = 2^(LOGQH-1) + 2^L1 - 2^L2 (+ 2^L3), wrapped to LOGQH bits
    function automatic logic [63:0] calc_qh(input int unsigned logqh,
                                            input int unsigned l1,
                                            input int unsigned l2,
                                            input int unsigned l3,
                                            input bit          use_l3);
        logic [63:0] v;
        v = (64'd1 << (logqh - 1)) + (64'd1 << l1) - (64'd1 << l2);
        if (use_l3) begin
            v = v + (64'd1 << l3);
        end
        return v & ((64'd1 << logqh) - 64'd1);
    endfunction

endpackage

// File: rtl/montgomery_stream_ctrl_fifo.sv
// First-word fall-through FIFO holding reducer results; occupancy exported as a count.
// Overflow is prevented upstream by credits, so writes are never refused here.
module mont_stream_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_wr_en,
    input  logic [WIDTH-1:0]             i_wr_data,
    input  logic                         i_rd_en,
    output logic [WIDTH-1:0]             o_rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_rd = i_rd_en && (r_count != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_wr_en, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/montgomery_stream_ctrl.sv
// Streaming initiator for the fixed-latency montgomery_shift reducer: multiplies operand
// pairs, tracks tokens through the reducer and buffers results behind a credit-guarded FIFO.
module montgomery_stream_ctrl
    import montgomery_pkg::*;
#(
    parameter int LOGQ       = 32,
    parameter int LOGQH      = 15,
    parameter int LOGT       = 32,
    parameter bit USE_L3     = 1'b1,
    parameter int LOGL1      = 5,
    parameter int LOGL2      = 5,
    parameter int LOGL3      = 5,
    parameter int MUL_LAT    = 2,
    parameter int RED_LAT    = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_cfg_we,
    input  logic [LOGL1-1:0]            i_cfg_L1,
    input  logic [LOGL2-1:0]            i_cfg_L2,
    input  logic [LOGL3-1:0]            i_cfg_L3,
    output logic                        o_cfg_busy,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic [LOGQ-1:0]             i_in_a,
    input  logic [LOGQ-1:0]             i_in_b,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [LOGT-1:0]             o_out_t,
    output logic [logc_of(LOGQ)-1:0]    o_red_C,
    output logic [LOGQH-1:0]            o_red_qH,
    output logic [LOGL1-1:0]            o_red_L1,
    output logic [LOGL2-1:0]            o_red_L2,
    output logic [LOGL3-1:0]            o_red_L3,
    input  logic [LOGT-1:0]             i_red_T
);
    localparam int LOGC = logc_of(LOGQ);
    localparam int VLEN = MUL_LAT + RED_LAT;
    localparam int CRW  = $clog2(FIFO_DEPTH + 1);

    // States: CFG_WAIT no config yet | RUN streaming | DRAIN flush pipe | APPLY load config
    ctrl_state_t      r_state;
    ctrl_state_t      w_next_state;
    logic             w_apply;

    logic [CRW-1:0]   r_credits;
    logic [VLEN-1:0]  r_vpipe;
    logic [LOGC-1:0]  r_mul [MUL_LAT];

    logic [LOGL1-1:0] r_pend_l1;
    logic [LOGL2-1:0] r_pend_l2;
    logic [LOGL3-1:0] r_pend_l3;
    logic             r_pend_dirty;

    logic [LOGQH-1:0] r_red_qh;
    logic [LOGL1-1:0] r_red_l1;
    logic [LOGL2-1:0] r_red_l2;
    logic [LOGL3-1:0] r_red_l3;

    logic             w_accept;
    logic             w_pop;
    logic [CRW-1:0]   w_fifo_count;

    assign o_in_ready = (r_state == RUN) && (r_credits != '0) && !i_cfg_we;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_pop      = o_out_valid && i_out_ready;
    assign o_cfg_busy = (r_state != RUN);

    always_comb begin
        w_next_state = r_state;
        w_apply      = 1'b0;
        case (r_state)
            CFG_WAIT: if (i_cfg_we) w_next_state = DRAIN;
            RUN:      if (i_cfg_we || r_pend_dirty) w_next_state = DRAIN;
            DRAIN:    if (r_vpipe == '0) w_next_state = APPLY;
            APPLY: begin
                w_apply      = 1'b1;
                w_next_state = RUN;
            end
            default:  w_next_state = CFG_WAIT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= CFG_WAIT;
            r_pend_l1    <= '0;
            r_pend_l2    <= '0;
            r_pend_l3    <= '0;
            r_pend_dirty <= 1'b0;
            r_red_qh     <= '0;
            r_red_l1     <= '0;
            r_red_l2     <= '0;
            r_red_l3     <= '0;
        end else begin
            r_state <= w_next_state;
            if (i_cfg_we) begin
                r_pend_l1 <= i_cfg_L1;
                r_pend_l2 <= i_cfg_L2;
                r_pend_l3 <= i_cfg_L3;
            end
            // A write landing during APPLY missed this copy; force another drain pass.
            if (r_state == APPLY && i_cfg_we) begin
                r_pend_dirty <= 1'b1;
            end else if (r_state == DRAIN) begin
                r_pend_dirty <= 1'b0;
            end
            if (w_apply) begin
                r_red_l1 <= r_pend_l1;
                r_red_l2 <= r_pend_l2;
                r_red_l3 <= r_pend_l3;
                r_red_qh <= LOGQH'(calc_qh(LOGQH, int'(r_pend_l1), int'(r_pend_l2),
                                           int'(r_pend_l3), USE_L3));
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_credits <= CRW'(FIFO_DEPTH);
            r_vpipe   <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                r_mul[i] <= '0;
            end
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_credits <= r_credits - 1'b1;
                2'b01:   r_credits <= r_credits + 1'b1;
                default: r_credits <= r_credits;
            endcase
            r_vpipe  <= {r_vpipe[VLEN-2:0], w_accept};
            r_mul[0] <= w_accept ? LOGC'(i_in_a) * LOGC'(i_in_b) : '0;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_mul[i] <= r_mul[i-1];
            end
        end
    end

    assign o_red_C  = r_mul[MUL_LAT-1];
    assign o_red_qH = r_red_qh;
    assign o_red_L1 = r_red_l1;
    assign o_red_L2 = r_red_l2;
    assign o_red_L3 = r_red_l3;

    mont_stream_fifo #(
        .WIDTH (LOGT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (r_vpipe[VLEN-1]),
        .i_wr_data (i_red_T),
        .i_rd_en   (w_pop),
        .o_rd_data (o_out_t),
        .o_count   (w_fifo_count)
    );

    assign o_out_valid = (w_fifo_count != '0);

endmodule

// File: tb/tb_montgomery_stream_ctrl.sv
// Self-checking bench: directed phases with random operands, a behavioural reducer stand-in
// and a queue of expected results computed from a*b and the configured modulus shape.
module tb_montgomery_stream_ctrl;
    import montgomery_pkg::*;

    localparam int LOGQ       = 32;
    localparam int LOGQH      = 15;
    localparam int LOGT       = 32;
    localparam int MUL_LAT    = 2;
    localparam int RED_LAT    = 5;
    localparam int FIFO_DEPTH = 8;

    logic              clk;
    logic              rst;
    logic              cfg_we;
    logic [4:0]        cfg_L1, cfg_L2, cfg_L3;
    logic              cfg_busy;
    logic              in_valid, in_ready;
    logic [LOGQ-1:0]   in_a, in_b;
    logic              out_valid, out_ready;
    logic [LOGT-1:0]   out_t;
    logic [63:0]       red_C;
    logic [LOGQH-1:0]  red_qH;
    logic [4:0]        red_L1, red_L2, red_L3;
    logic [LOGT-1:0]   red_T;

    montgomery_stream_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cfg_we    (cfg_we),
        .i_cfg_L1    (cfg_L1),
        .i_cfg_L2    (cfg_L2),
        .i_cfg_L3    (cfg_L3),
        .o_cfg_busy  (cfg_busy),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_a      (in_a),
        .i_in_b      (in_b),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_t     (out_t),
        .o_red_C     (red_C),
        .o_red_qH    (red_qH),
        .o_red_L1    (red_L1),
        .o_red_L2    (red_L2),
        .o_red_L3    (red_L3),
        .i_red_T     (red_T)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in reducer: an arbitrary function of (C, qH) with exactly RED_LAT cycles of delay.
    function automatic logic [31:0] red_f(input logic [63:0] c, input logic [14:0] qh);
        return c[31:0] + c[63:32] * 32'd3 + {17'd0, qh};
    endfunction

    logic [31:0] rr [RED_LAT];
    always @(posedge clk) begin
        rr[0] <= red_f(red_C, red_qH);
        for (int i = 1; i < RED_LAT; i++) rr[i] <= rr[i-1];
    end
    assign red_T = rr[RED_LAT-1];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc;
    int          first_acc, first_ov;
    int          n_acc, n_pop;
    int          base_acc, base_pop, n;
    bit          acc_last;
    logic [31:0] exp_q [$];
    logic [63:0] dl [MUL_LAT];
    logic [14:0] qh_model;
    int          l1r, l2r, l3r;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [14:0] model_qh(input int l1, input int l2, input int l3);
        longint v;
        v = (longint'(1) << 14) + (longint'(1) << l1) - (longint'(1) << l2) + (longint'(1) << l3);
        return v[14:0];
    endfunction

    task automatic tick();
        bit          pop;
        logic [63:0] prod;
        @(negedge clk);
        acc_last = in_valid && in_ready;
        pop      = out_valid && out_ready;
        prod     = acc_last ? 64'(in_a) * 64'(in_b) : 64'd0;
        if (pop) begin
            chk("pop_has_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("out_t", 64'(out_t), 64'(exp_q.pop_front()));
            n_pop++;
        end
        if (acc_last) begin
            exp_q.push_back(red_f(prod, qh_model));
            n_acc++;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = MUL_LAT - 1; i > 0; i--) dl[i] = dl[i-1];
        dl[0] = prod;
        chk("red_C", red_C, dl[MUL_LAT-1]);
        if (acc_last && first_acc < 0) first_acc = cyc;
        if (out_valid && first_ov < 0) first_ov = cyc;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit rnd_ready);
        int k;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        k        = 0;
        do begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end while (!acc_last && k < 40);
        chk("send_accepted", 64'(acc_last), 64'd1);
    endtask

    task automatic drain();
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k         = 0;
        while (exp_q.size() != 0 && k < 100) begin
            tick();
            k++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_cfg(input int l1, input int l2, input int l3);
        int k;
        cfg_L1 = 5'(l1);
        cfg_L2 = 5'(l2);
        cfg_L3 = 5'(l3);
        cfg_we = 1'b1;
        #1;
        chk("cfg_we_blocks_ready", 64'(in_ready), 64'd0);
        tick();
        cfg_we   = 1'b0;
        qh_model = model_qh(l1, l2, l3);
        k        = 0;
        while (cfg_busy && k < 100) begin
            chk("busy_in_ready", 64'(in_ready), 64'd0);
            tick();
            k++;
        end
        chk("cfg_done", 64'(cfg_busy), 64'd0);
        chk("red_qH", 64'(red_qH), 64'(qh_model));
        chk("red_L1", 64'(red_L1), 64'(l1));
        chk("red_L2", 64'(red_L2), 64'(l2));
        chk("red_L3", 64'(red_L3), 64'(l3));
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_L1 = '0; cfg_L2 = '0; cfg_L3 = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        qh_model = '0; cyc = 0; first_acc = -1; first_ov = -1; n_acc = 0; n_pop = 0;
        for (int i = 0; i < MUL_LAT; i++) dl[i] = 64'd0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cfg_busy", 64'(cfg_busy), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_red_C", red_C, 64'd0);
        chk("rst_red_qH", 64'(red_qH), 64'd0);
        chk("rst_credits", 64'(dut.r_credits), 64'(FIFO_DEPTH));
        rst = 1'b0;

        // first configuration
        do_cfg(3, 1, 0);
        chk("qH_first_const", 64'(red_qH), 64'h4007);
        chk("run_in_ready", 64'(in_ready), 64'd1);

        // continuous stream a=1, b=k
        out_ready = 1'b1;
        first_acc = -1; first_ov = -1; base_pop = n_pop;
        for (int k = 1; k <= 20; k++) begin
            if (k <= FIFO_DEPTH) begin
                #0;
                in_valid = 1'b1;
                #1;
                chk("stream_in_ready", 64'(in_ready), 64'd1);
            end
            send(32'd1, 32'(k), 1'b0);
        end
        drain();
        chk("stream_latency", 64'(first_ov - first_acc), 64'(MUL_LAT + RED_LAT));
        chk("stream_pops", 64'(n_pop - base_pop), 64'd20);

        // backpressure: credits limit accepts to FIFO_DEPTH
        out_ready = 1'b0; in_valid = 1'b1;
        base_acc = n_acc; base_pop = n_pop;
        for (int k = 0; k < 12; k++) begin
            in_a = $urandom(); in_b = $urandom();
            tick();
        end
        chk("bp_accepts", 64'(n_acc - base_acc), 64'(FIFO_DEPTH));
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        tick();
        chk("bp_one_more_accept", 64'(n_acc - base_acc), 64'(FIFO_DEPTH + 1));
        chk("bp_one_pop", 64'(n_pop - base_pop), 64'd1);
        drain();
        chk("bp_out_valid_idle", 64'(out_valid), 64'd0);

        // mid-stream reconfiguration with random backpressure
        for (int k = 0; k < 6; k++) send($urandom(), $urandom(), 1'b1);
        in_a = $urandom(); in_b = $urandom();
        do_cfg(4, 2, 1);
        chk("qH_second_const", 64'(red_qH), 64'h400E);
        for (int k = 0; k < 10; k++) send($urandom(), $urandom(), 1'b1);
        drain();

        // asynchronous reset with tokens in flight and in the FIFO
        out_ready = 1'b0;
        for (int k = 0; k < FIFO_DEPTH; k++) send($urandom(), $urandom(), 1'b0);
        in_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_fifo_count", 64'(dut.w_fifo_count), 64'd3);
        chk("pre_rst_in_flight", 64'($countones(dut.r_vpipe)), 64'd5);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_credits", 64'(dut.r_credits), 64'(FIFO_DEPTH));
        chk("arst_state", 64'(dut.r_state), 64'(CFG_WAIT));
        chk("arst_cfg_busy", 64'(cfg_busy), 64'd1);
        chk("arst_red_C", red_C, 64'd0);
        exp_q.delete();
        for (int i = 0; i < MUL_LAT; i++) dl[i] = 64'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("post_rst_no_stale", 64'(out_valid), 64'd0);
        end
        l1r = int'($urandom_range(0, 31));
        l2r = int'($urandom_range(0, 31));
        l3r = int'($urandom_range(0, 31));
        do_cfg(l1r, l2r, l3r);
        for (int k = 0; k < 15; k++) send($urandom(), $urandom(), 1'b1);
        drain();

        // full-width product corner
        out_ready = 1'b1;
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        in_valid = 1'b0;
        for (int k = 1; k < MUL_LAT; k++) tick();
        chk("max_red_C", red_C, 64'hFFFF_FFFE_0000_0001);
        drain();

        chk("final_credits", 64'(dut.r_credits), 64'(FIFO_DEPTH));
        chk("final_out_valid", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
